trigger_encoder: RTL

Generates the registered trigger_ready / trigger_vector[3:0] pair that the acquisition-side trigger decoder consumes. The decoder asserts trigger_start when trigger_ready and any trigger_vector bit are high in the same cycle.

---
 rtl/trigger_encoder.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/trigger_encoder.sv
// Trigger encoder: four-source trigger qualification with arm/disarm, holdoff, missed-trigger pulse and fire counter.
// Optional build macro TRIG_DEBOUNCE_EN adds a DEBOUNCE-cycle qualifier on the synchronized external trigger.
module trigger_encoder #(
  parameter int PERIOD_W    = 24,
  parameter int HOLDOFF_W   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic [3:0]           src_mask,
  input  logic                 ext_trig_in,
  input  logic                 sw_trig,
  input  logic                 level_hit,
  input  logic [PERIOD_W-1:0]  period,
  input  logic [HOLDOFF_W-1:0] holdoff,
  output logic                 trigger_ready,
  output logic [3:0]           trigger_vector,
  output logic                 missed_trig,
  output logic [15:0]          trig_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    FIRE    = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t               state_r;
  logic                 ready_r;
  logic [3:0]           vector_r;
  logic                 missed_r;
  logic [15:0]          count_r;
  logic [HOLDOFF_W-1:0] hold_cnt_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                 lvl_prev_r;
  logic [PERIOD_W-1:0]  per_cnt_r;

  logic                 ext_sync_s;
  logic                 ext_evt_s;
  logic                 lvl_evt_s;
  logic                 per_evt_s;
  logic                 active_s;
  logic [PERIOD_W-1:0]  per_last_s;
  logic [3:0]           raw_s;

  assign ext_sync_s = sync_r[SYNC_STAGES-1];
  assign active_s   = (state_r != IDLE);
  assign per_last_s = period - PERIOD_W'(1);

  // Synchronizer chain for the asynchronous external trigger pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], ext_trig_in};
    end
  end

`ifdef TRIG_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE - 1);

  logic [DB_W-1:0] deb_cnt_r;
  logic            ext_qual_r;

  // The event fires once per qualified high level; the level must drop before re-arming.
  always_comb begin
    ext_evt_s = 1'b0;
    if (ext_sync_s && (deb_cnt_r == DB_MAX) && !ext_qual_r) begin
      ext_evt_s = 1'b1;
    end else begin
      ext_evt_s = 1'b0;
    end
  end

  // Consecutive-high counter and qualified-level latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_r  <= {DB_W{1'b0}};
      ext_qual_r <= 1'b0;
    end else if (!ext_sync_s) begin
      deb_cnt_r  <= {DB_W{1'b0}};
      ext_qual_r <= 1'b0;
    end else begin
      if (deb_cnt_r != DB_MAX) begin
        deb_cnt_r <= deb_cnt_r + DB_W'(1);
      end
      ext_qual_r <= ext_qual_r | ext_evt_s;
    end
  end
`else
  logic ext_prev_r;

  assign ext_evt_s = ext_sync_s & ~ext_prev_r;

  // Previous synchronized value for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_prev_r <= 1'b0;
    end else begin
      ext_prev_r <= ext_sync_s;
    end
  end
`endif

  assign lvl_evt_s = level_hit & ~lvl_prev_r;

  // Previous level_hit for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_prev_r <= 1'b0;
    end else begin
      lvl_prev_r <= level_hit;
    end
  end

  // Periodic event at the last count of the interval.
  always_comb begin
    per_evt_s = 1'b0;
    if (active_s && (period != {PERIOD_W{1'b0}}) && (per_cnt_r == per_last_s)) begin
      per_evt_s = 1'b1;
    end else begin
      per_evt_s = 1'b0;
    end
  end

  // Periodic timer; wraps on >= so a shrunk period never strands the count above it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_r <= {PERIOD_W{1'b0}};
    end else if (!active_s || (period == {PERIOD_W{1'b0}}) || (per_cnt_r >= per_last_s)) begin
      per_cnt_r <= {PERIOD_W{1'b0}};
    end else begin
      per_cnt_r <= per_cnt_r + PERIOD_W'(1);
    end
  end

  assign raw_s = {lvl_evt_s, per_evt_s, sw_trig, ext_evt_s} & src_mask;

  // Main state machine; ready/vector/missed/count are all registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      ready_r    <= 1'b0;
      vector_r   <= 4'b0000;
      missed_r   <= 1'b0;
      count_r    <= 16'h0000;
      hold_cnt_r <= {HOLDOFF_W{1'b0}};
    end else begin
      missed_r <= 1'b0;
      if (disarm) begin
        state_r  <= IDLE;
        ready_r  <= 1'b0;
        vector_r <= 4'b0000;
      end else begin
        case (state_r)
          IDLE: begin
            vector_r <= 4'b0000;
            if (arm) begin
              state_r <= ARMED;
              ready_r <= 1'b1;
              count_r <= 16'h0000;
            end else begin
              ready_r <= 1'b0;
            end
          end
          ARMED: begin
            ready_r <= 1'b1;
            if (|raw_s) begin
              state_r  <= FIRE;
              vector_r <= raw_s;
              count_r  <= count_r + 16'h0001;
            end else begin
              vector_r <= 4'b0000;
            end
          end
          FIRE: begin
            vector_r <= 4'b0000;
            missed_r <= |raw_s;
            if (holdoff != {HOLDOFF_W{1'b0}}) begin
              state_r    <= HOLDOFF;
              ready_r    <= 1'b0;
              hold_cnt_r <= holdoff - HOLDOFF_W'(1);
            end else begin
              state_r <= ARMED;
              ready_r <= 1'b1;
            end
          end
          HOLDOFF: begin
            vector_r <= 4'b0000;
            missed_r <= |raw_s;
            if (hold_cnt_r == {HOLDOFF_W{1'b0}}) begin
              state_r <= ARMED;
              ready_r <= 1'b1;
            end else begin
              hold_cnt_r <= hold_cnt_r - HOLDOFF_W'(1);
              ready_r    <= 1'b0;
            end
          end
          default: begin
            state_r  <= IDLE;
            ready_r  <= 1'b0;
            vector_r <= 4'b0000;
          end
        endcase
      end
    end
  end

  assign trigger_ready  = ready_r;
  assign trigger_vector = vector_r;
  assign missed_trig    = missed_r;
  assign trig_count     = count_r;

endmodule
